// File: rtl/weight_buf_if.sv
// Handshake bundle for weight_buf: producer write port and MAC-array read stream.
interface weight_buf_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 8
);
    logic [31:0]   weight_waddr;
    logic [DW-1:0] weight_wdata;
    logic          weight_wen;
    logic          weight_done;
    logic          buf_ready;
    logic          wr_ovf;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] rd_idx;
    logic [7:0]    rd_och;
    logic          rd_last;
    logic          rd_vld;
    logic          rd_rdy;
    logic          rd_perr;

    modport master (
        output weight_waddr, weight_wdata, weight_wen, weight_done, rd_rdy,
        input  buf_ready, wr_ovf, rd_data, rd_idx, rd_och, rd_last, rd_vld, rd_perr
    );

    modport slave (
        input  weight_waddr, weight_wdata, weight_wen, weight_done, rd_rdy,
        output buf_ready, wr_ovf, rd_data, rd_idx, rd_och, rd_last, rd_vld, rd_perr
    );
endinterface

// File: rtl/weight_buf.sv
// Ping-pong weight buffer: fills one bank from the weight bus while the other streams to the MACs.
// Optional per-byte parity storage and checking is enabled with WBUF_PARITY_EN.
module weight_buf #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 160,
    parameter int unsigned AW    = 8
) (
    input logic         clk,
    input logic         rst_n,
    weight_buf_if.slave bus
);
`ifdef WBUF_PARITY_EN
    localparam int unsigned NB = DW / 8;
    localparam int unsigned MW = DW + NB;
`else
    localparam int unsigned MW = DW;
`endif

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    logic [MW-1:0] mem_q [2][DEPTH];
    logic [7:0]    och_q [2];
    logic [1:0]    full_q, full_d;
    logic          wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic          wr_ovf_q, wr_ovf_d, buf_ready_q;
    state_e        state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;

    // Two-entry output skid fed straight from the RAM read port.
    logic [DW-1:0] sk_data_q [2];
    logic [AW-1:0] sk_idx_q [2];
    logic [1:0]    sk_last_q;
    logic          sk_hd_q;
    logic [1:0]    sk_cnt_q;
    logic          push_slot;

    logic [5:0]    wpos, wch;
    logic          waddr_ok, wr_full, wr_en, commit, issue, pop, last_pop;
    logic [AW-1:0] widx;
    logic [MW-1:0] wr_word, rd_word;
    logic          unused_waddr;

    assign unused_waddr = ^bus.weight_waddr[22:12];

    always_comb begin
        wpos     = bus.weight_waddr[11:6];
        wch      = bus.weight_waddr[5:0];
        waddr_ok = (wpos <= 6'd8) && (wch <= 6'd15);
        widx     = bus.weight_waddr[31] ? AW'(DEPTH - 16) + AW'(wch)
                                        : AW'({wpos[3:0], wch[3:0]});
        wr_full  = full_q[wr_bank_q];
        wr_en    = bus.weight_wen && waddr_ok && !wr_full;
        commit   = bus.weight_done && !wr_full;
        rd_word  = mem_q[rd_bank_q][ptr_q[AW-1:0]];
        pop      = (sk_cnt_q != 2'd0) && bus.rd_rdy;
        last_pop = pop && sk_last_q[sk_hd_q];
        issue    = (state_q == StStream) && (ptr_q < (AW+1)'(DEPTH)) &&
                   ((sk_cnt_q < 2'd2) || pop);
        push_slot = sk_hd_q ^ sk_cnt_q[0];
    end

`ifdef WBUF_PARITY_EN
    logic [NB-1:0] wpar, rpar;
    logic [1:0]    sk_perr_q;
    logic          rd_bad;

    always_comb begin
        wpar = '0;
        rpar = '0;
        for (int i = 0; i < int'(NB); i++) begin
            wpar[i] = ^bus.weight_wdata[8*i +: 8];
            rpar[i] = ^rd_word[8*i +: 8];
        end
    end
    assign wr_word = {wpar, bus.weight_wdata};
    assign rd_bad  = |(rpar ^ rd_word[MW-1:DW]);

    always_ff @(posedge clk) begin
        if (!rst_n)     sk_perr_q <= '0;
        else if (issue) sk_perr_q[push_slot] <= rd_bad;
    end
    assign bus.rd_perr = pop && sk_perr_q[sk_hd_q];
`else
    assign wr_word     = bus.weight_wdata;
    assign bus.rd_perr = 1'b0;
`endif

    // Commit and release always target different banks, so both may land in one cycle.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_ovf_d  = wr_ovf_q;
        if ((bus.weight_wen || bus.weight_done) && wr_full) wr_ovf_d = 1'b1;
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end
        unique case (state_q)
            StIdle: begin
                ptr_d = '0;
                if (full_q[rd_bank_q]) state_d = StStream;
            end
            StStream: begin
                if (issue) ptr_d = ptr_q + 1'b1;
                if (last_pop) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    state_d           = StIdle;
                    ptr_d             = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][widx] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            full_q       <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            wr_ovf_q     <= 1'b0;
            buf_ready_q  <= 1'b1;
            och_q[0]     <= '0;
            och_q[1]     <= '0;
            sk_data_q[0] <= '0;
            sk_data_q[1] <= '0;
            sk_idx_q[0]  <= '0;
            sk_idx_q[1]  <= '0;
            sk_last_q    <= '0;
            sk_hd_q      <= 1'b0;
            sk_cnt_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            full_q      <= full_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_ovf_q    <= wr_ovf_d;
            buf_ready_q <= ~full_q[wr_bank_q];
            if (wr_en) och_q[wr_bank_q] <= bus.weight_waddr[30:23];
            if (issue) begin
                sk_data_q[push_slot] <= rd_word[DW-1:0];
                sk_idx_q[push_slot]  <= ptr_q[AW-1:0];
                sk_last_q[push_slot] <= (ptr_q == (AW+1)'(DEPTH - 1));
            end
            sk_hd_q  <= sk_hd_q ^ pop;
            sk_cnt_q <= sk_cnt_q + 2'(issue) - 2'(pop);
        end
    end

    assign bus.buf_ready = buf_ready_q;
    assign bus.wr_ovf    = wr_ovf_q;
    assign bus.rd_vld    = (sk_cnt_q != 2'd0);
    assign bus.rd_data   = sk_data_q[sk_hd_q];
    assign bus.rd_idx    = sk_idx_q[sk_hd_q];
    assign bus.rd_last   = (sk_cnt_q != 2'd0) && sk_last_q[sk_hd_q];
    assign bus.rd_och    = och_q[rd_bank_q];
endmodule

// File: tb/tb_weight_buf.sv
// Randomized bench for weight_buf: a queue-of-sets model predicts every streamed word.
module tb_weight_buf;
    localparam int DEPTH = 160;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    weight_buf_if #(.DW(32), .AW(8)) bus ();

    weight_buf #(.DW(32), .DEPTH(DEPTH), .AW(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [31:0] d;
        int          idx;
        logic [7:0]  och;
        bit          perr;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] cur_set[DEPTH];
    logic [7:0]  cur_tag;
    int          model_cnt;
    bit          exp_ovf;
    int          perr_at = -1;
    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 1;

    bit          hold_v;
    logic [31:0] hold_d;
    logic [7:0]  hold_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Consumer ready pattern: 0 stalled, 1 always, 2 toggling, 3 random.
    always @(posedge clk) begin
        #2;
        case (rdy_mode)
            0:       bus.rd_rdy = 1'b0;
            1:       bus.rd_rdy = 1'b1;
            2:       bus.rd_rdy = ~bus.rd_rdy;
            default: bus.rd_rdy = 1'($urandom_range(1, 0));
        endcase
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v && bus.rd_vld) begin
                check("hold_data", bus.rd_data, hold_d);
                check("hold_idx", bus.rd_idx, hold_i);
            end
            if (bus.rd_vld && bus.rd_rdy) begin
                if (exp_q.size() == 0) begin
                    check("spurious_vld", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", bus.rd_data, e.d);
                    check("rd_idx", bus.rd_idx, e.idx);
                    check("rd_och", bus.rd_och, e.och);
                    check("rd_last", bus.rd_last, e.idx == DEPTH - 1);
                    check("rd_perr", bus.rd_perr, e.perr);
                    if (e.idx == DEPTH - 1) model_cnt--;
                end
            end
            hold_v = bus.rd_vld && !bus.rd_rdy;
            hold_d = bus.rd_data;
            hold_i = bus.rd_idx;
        end
    end

    task automatic write_word(input bit k1, input int pos, input int ch,
                              input logic [31:0] data, input logic [7:0] tag);
        bus.weight_waddr = {k1, tag, 11'b0, pos[5:0], ch[5:0]};
        bus.weight_wdata = data;
        bus.weight_wen   = 1'b1;
        if (model_cnt == 2) exp_ovf = 1'b1;
        else if (pos <= 8 && ch <= 15) begin
            cur_set[k1 ? 144 + ch : pos * 16 + ch] = data;
            cur_tag = tag;
        end
        @(posedge clk); #1;
        bus.weight_wen = 1'b0;
    endtask

    task automatic write_idx(input int idx, input logic [31:0] data, input logic [7:0] tag);
        if (idx >= 144) write_word(1'b1, 0, idx - 144, data, tag);
        else            write_word(1'b0, idx / 16, idx % 16, data, tag);
    endtask

    task automatic commit_set();
        exp_t e;
        bus.weight_done = 1'b1;
        if (model_cnt == 2) exp_ovf = 1'b1;
        else begin
            for (int i = 0; i < DEPTH; i++) begin
                e.d = cur_set[i]; e.idx = i; e.och = cur_tag; e.perr = (i == perr_at);
                exp_q.push_back(e);
            end
            model_cnt++;
            perr_at = -1;
        end
        @(posedge clk); #1;
        bus.weight_done = 1'b0;
    endtask

    task automatic fill_random(input logic [7:0] tag, input bit shuffle);
        int order[DEPTH];
        int j, t;
        for (int i = 0; i < DEPTH; i++) order[i] = i;
        if (shuffle) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = order[i]; order[i] = order[j]; order[j] = t;
            end
        end
        for (int i = 0; i < DEPTH; i++) begin
            write_idx(order[i], $urandom, tag);
            if ($urandom_range(7, 0) == 0) begin @(posedge clk); #1; end
        end
    endtask

    task automatic wait_drain();
        int budget = 3000;
        while ((exp_q.size() != 0 || model_cnt != 0) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("drain_timeout", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int budget;
        rst_n = 1'b0;
        bus.weight_waddr = '0;
        bus.weight_wdata = '0;
        bus.weight_wen   = 1'b0;
        bus.weight_done  = 1'b0;
        model_cnt = 0;
        exp_ovf   = 1'b0;
        cur_tag   = '0;
        for (int i = 0; i < DEPTH; i++) cur_set[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_buf_ready", bus.buf_ready, 1);
        check("rst_wr_ovf", bus.wr_ovf, 0);
        check("rst_rd_vld", bus.rd_vld, 0);
        check("rst_rd_last", bus.rd_last, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_idx", bus.rd_idx, 0);
        check("rst_rd_och", bus.rd_och, 0);
        check("rst_rd_perr", bus.rd_perr, 0);
        rst_n = 1'b1;

        // Single set, in order, value = idx; check first-word latency.
        rdy_mode = 1;
        for (int i = 0; i < DEPTH; i++) write_idx(i, 32'(i), 8'h05);
        commit_set();
        check("lat_c0_vld", bus.rd_vld, 0);
        @(posedge clk); #1;
        check("lat_c1_vld", bus.rd_vld, 0);
        @(posedge clk); #1;
        check("lat_c2_vld", bus.rd_vld, 1);
        wait_drain();
        check("t1_buf_ready", bus.buf_ready, model_cnt < 2);

        // 1x1 words first, then 3x3 in reverse position order.
        for (int c = 0; c < 16; c++) write_word(1'b1, 0, c, 32'(144 + c), 8'h22);
        for (int p = 8; p >= 0; p--)
            for (int c = 0; c < 16; c++) write_word(1'b0, p, c, 32'(p * 16 + c), 8'h22);
        commit_set();
        wait_drain();

        // Illegal addresses mixed into a random set must be ignored silently.
        rdy_mode = 3;
        fill_random(8'h55, 1'b1);
        write_word(1'b0, 9, 0, 32'hDEAD_BEEF, 8'h66);
        write_word(1'b0, 0, 16, 32'hDEAD_BEEF, 8'h66);
        write_word(1'b1, 0, 20, 32'hDEAD_BEEF, 8'h66);
        commit_set();
        wait_drain();
        check("t5_wr_ovf", bus.wr_ovf, exp_ovf);

        // Ping-pong: B fills while A drains with toggling ready.
        rdy_mode = 2;
        fill_random(8'h01, 1'b0);
        commit_set();
        fill_random(8'h02, 1'b1);
        commit_set();
        wait_drain();
        check("t3_buf_ready", bus.buf_ready, model_cnt < 2);

        // Overflow: both banks held, then an extra write and commit.
        rdy_mode = 0;
        fill_random(8'h03, 1'b0);
        commit_set();
        fill_random(8'h04, 1'b1);
        commit_set();
        write_idx(0, 32'h1234_5678, 8'h09);
        commit_set();
        repeat (3) @(posedge clk);
        #1;
        check("t4_buf_ready", bus.buf_ready, model_cnt < 2);
        check("t4_wr_ovf", bus.wr_ovf, exp_ovf);
        rdy_mode = 3;
        wait_drain();

        // Reset in the middle of a stream.
        rdy_mode = 1;
        fill_random(8'h06, 1'b0);
`ifdef WBUF_PARITY_EN
        dut.mem_q[dut.wr_bank_q][7][32] = ~dut.mem_q[dut.wr_bank_q][7][32];
        perr_at = 7;
`endif
        commit_set();
        budget = 400;
        while (!(bus.rd_vld && bus.rd_idx == 8'd50) && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (budget == 0) check("t6_reach_idx50", 0, 1);
        rst_n = 1'b0;
        exp_q.delete();
        model_cnt = 0;
        exp_ovf   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("t6_rd_vld", bus.rd_vld, 0);
        check("t6_buf_ready", bus.buf_ready, 1);
        check("t6_wr_ovf", bus.wr_ovf, exp_ovf);
        fill_random(8'h07, 1'b1);
        commit_set();
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/weight_buf.md
Name: weight_buf

Overview:
- Ping-pong weight storage between the weight bus interface unit and the MAC array.
- Captures the 160-word weight stream for one output channel: 144 words of 3x3 kernel followed by 16 words of 1x1 kernel.
- Commits the captured set on the producer's done pulse.
- Streams committed sets to the MAC array in canonical order over a valid/ready port. The next output channel fills the other bank while the MAC array drains the current one.

Parameters:
- DW, 32, weight word width (4 x int8).
- DEPTH, 160, words per bank (9*16 for 3x3 plus 16 for 1x1).
- AW, 8, bank index width; must satisfy 2^AW >= DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- weight_waddr  in  32  write address: bit31 = kernel type (0 = 3x3, 1 = 1x1); [30:23] = out-channel tag; [11:6] = kernel position 0..8; [5:0] = in-channel word 0..15
- weight_wdata  in  DW  write data
- weight_wen  in  1  write strobe, one word per cycle
- weight_done  in  1  one-cycle pulse; commits the current write bank
- buf_ready  out  1  high when at least one bank is free to fill; the controller only issues weight_start while this is high
- wr_ovf  out  1  sticky; a write or commit was attempted with no free bank
- rd_data  out  DW  read word
- rd_idx  out  AW  index of rd_data within the set, 0..159
- rd_och  out  8  out-channel tag of the set being read
- rd_last  out  1  high with the word at index 159
- rd_vld  out  1  rd_data is valid
- rd_rdy  in  1  consumer accepts when rd_vld & rd_rdy
- rd_perr  out  1  parity error flag (see Optional Feature)

Behaviour:
- Reset values: buf_ready = 1, wr_ovf = 0, rd_vld = 0, rd_last = 0, rd_data = 0, rd_idx = 0, rd_och = 0, rd_perr = 0. Both banks empty; wr_bank = 0; rd_bank = 0; read pointer = 0.
- Write index:
  - 3x3 (bit31 = 0): idx = pos*16 + ch.
  - 1x1 (bit31 = 1): idx = 144 + ch.
  - Addresses with pos > 8 or ch > 15 are ignored (no write, no flag).
- Tag capture: on every accepted write, the bank's och tag is set to waddr[30:23].
- Bank flags: full[1:0].
  - weight_done sets full[wr_bank] and toggles wr_bank.
  - If weight_wen or weight_done arrives while full[wr_bank] = 1: the write is dropped, the commit is ignored, and wr_ovf sets. wr_ovf clears only on reset.
- buf_ready = ~full[wr_bank], registered, updated the cycle after any flag change.
- Read FSM states: IDLE, STREAM.
  - IDLE -> STREAM when full[rd_bank] = 1.
  - In STREAM, reads are issued at pointer 0..159.
  - RAM read latency is 1 cycle into an output register; a 2-entry skid ensures no bubble under continuous rd_rdy. Throughput is 1 word/cycle.
  - First rd_vld occurs 2 cycles after full[rd_bank] rises.
  - rd_vld is held with stable data/idx while rd_rdy = 0.
  - When the word with rd_last = 1 is accepted: clear full[rd_bank], toggle rd_bank, return to IDLE. If the other bank is already full, the next STREAM starts immediately; the gap is 2 cycles.
- Simultaneous commit of one bank and release of the other in the same cycle: both take effect; buf_ready stays 1.
- Writing bank A while reading bank B is always legal. Reads and writes never target the same bank, because a bank is readable only once full.
- A mid-operation reset discards both banks' contents and flags. RAM contents need not be cleared.

Optional Feature:
- Macro: WBUF_PARITY_EN.
- Defined:
  - Each word stores 4 even-parity bits, one per byte, computed on write.
  - On read, parity is recomputed. rd_perr pulses high with the offending word (rd_vld & rd_rdy cycle) on any byte mismatch.
  - Data is passed through unmodified.
- Undefined: no parity storage; rd_perr tied to 0.

Test Plan:
1. Single set: write 160 words with data = idx, tag 8'h05, then pulse weight_done. Expect rd_vld 2 cycles later, words 0..159 in order with rd_och = 5 and rd_last at 159, then buf_ready stays 1.
2. Shuffled write order: write the 1x1 words first, then the 3x3 words in reverse pos order. Read-out is still idx-ordered, with value(idx) = idx.
3. Ping-pong: commit set A (tag 1), then fill set B (tag 2) while A streams with rd_rdy toggling 1/0. Expect A fully read, then B, no lost or duplicated words, and rd_data stable while rd_rdy = 0.
4. Overflow: commit two sets with rd_rdy = 0, then write one word and pulse done. Expect buf_ready = 0, wr_ovf = 1, and both stored sets unchanged on read-out.
5. Illegal address: pos = 9 with data 32'hDEAD_BEEF. Expect no effect on any stored word and no wr_ovf.
6. Reset mid-stream at word 50 (with WBUF_PARITY_EN: force a bit flip in word 7 and expect rd_perr = 1 only with idx 7). After reset, rd_vld = 0, buf_ready = 1, and a new set reads from idx 0.
